mor1kx_fwft_fifo: RTL and testbench

- Single-clock, first-word-fall-through (FWFT) FIFO.
- Acts as the initiator for the team's single-clock simple dual-port RAM: it drives the RAM's write port on push and its read port on prefetch.
- Presents a valid/ready pop interface with one registered output entry.
- Intended for store-buffer and bus-queue use inside the CPU.

---
 rtl/mor1kx_fwft_fifo_pkg.sv | 7 +
 rtl/mor1kx_fwft_fifo_ram.sv | 20 ++
 rtl/mor1kx_fwft_fifo.sv | 60 ++++++
 tb/tb_mor1kx_fwft_fifo.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mor1kx_fwft_fifo_pkg.sv
// mor1kx_fwft_fifo_pkg: shared constants and pointer occupancy helper for the FWFT FIFO
package mor1kx_fwft_fifo_pkg;
  localparam int FIFO_PTR_W = 5;
  function automatic int unsigned ptr_occupancy(input int unsigned wptr, input int unsigned rptr, input int ptr_w);
    return (wptr - rptr) & ((32'd1 << ptr_w) - 32'd1);
  endfunction
endpackage

// File: rtl/mor1kx_fwft_fifo_ram.sv
// mor1kx_fwft_fifo_ram: single-clock simple dual-port RAM with registered read data
module mor1kx_fwft_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ENABLE_BYPASS = 0
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    if (re) dout <= (ENABLE_BYPASS != 0 && we && waddr == raddr) ? din : mem[raddr];
  end
endmodule

// File: rtl/mor1kx_fwft_fifo.sv
// mor1kx_fwft_fifo: first-word-fall-through FIFO, RAM storage plus the RAM's registered read as output stage
module mor1kx_fwft_fifo
  import mor1kx_fwft_fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = FIFO_PTR_W - 1,
  parameter int DATA_WIDTH = 32,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   almost_full
);
  localparam int PW = DEPTH_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << DEPTH_WIDTH);
  logic [PW-1:0] wptr, rptr, ram_cnt, count_next;
  logic push, pop, re;
  assign ram_cnt = PW'(ptr_occupancy(32'(wptr), 32'(rptr), PW));
  // wr_ready deliberately ignores a same-cycle pop so there is no pop-to-push combinational path
  assign wr_ready = rst_n && !flush && ram_cnt != DEPTH;
  assign push = wr_valid && wr_ready;
  assign pop = rd_valid && rd_ready;
  assign re = ram_cnt != '0 && (!rd_valid || rd_ready) && !flush;
  assign count_next = count + PW'(push) - PW'(pop);
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr <= '0;
      rptr <= '0;
      rd_valid <= 1'b0;
      count <= '0;
      almost_full <= 1'b0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(re);
      rd_valid <= re || (rd_valid && !rd_ready);
      count <= count_next;
      almost_full <= count_next >= PW'(ALMOST_FULL_LEVEL);
    end
  end
  mor1kx_fwft_fifo_ram #(
    .ADDR_WIDTH(DEPTH_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .ENABLE_BYPASS(0)
  ) u_ram (
    .clk(clk),
    .raddr(rptr[DEPTH_WIDTH-1:0]),
    .re(re),
    .waddr(wptr[DEPTH_WIDTH-1:0]),
    .we(push),
    .din(wr_data),
    .dout(rd_data)
  );
endmodule

// File: tb/tb_mor1kx_fwft_fifo.sv
// tb_mor1kx_fwft_fifo: vector table, directed corner sequences and random traffic against a queue model
module tb_mor1kx_fwft_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush, wr_valid, rd_ready, wr_ready, rd_valid, almost_full;
  logic [31:0] wr_data, rd_data;
  logic [4:0] count;
  mor1kx_fwft_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .almost_full(almost_full)
  );
  int checks = 0, failures = 0;
  logic [31:0] q[$];
  logic [31:0] sent[$];
  logic [31:0] got[$];
  bit ov;
  logic s_wr_ready, s_rd_valid;
  logic [31:0] s_count, s_rd_data;
  typedef struct {
    bit r, f, wv;
    logic [31:0] wd;
    bit rr, ewr, erv;
    int ecnt;
    logic [31:0] edata;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  // one clock: drive, sample at negedge against the model, then advance the model at the edge
  task automatic cyc(input bit r, input bit f, input bit wv, input logic [31:0] wd, input bit rr);
    int ram;
    bit exp_wr, re;
    rst_n = r; flush = f; wr_valid = wv; wr_data = wd; rd_ready = rr;
    @(negedge clk);
    s_wr_ready = wr_ready; s_rd_valid = rd_valid; s_count = 32'(count); s_rd_data = rd_data;
    ram = q.size() - int'(ov);
    exp_wr = r && !f && ram != 16;
    chk("wr_ready", 32'(wr_ready), 32'(exp_wr));
    chk("rd_valid", 32'(rd_valid), 32'(ov));
    chk("count", 32'(count), 32'(q.size()));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 12));
    if (ov) chk("rd_data", rd_data, q[0]);
    if (r && !f && s_rd_valid && rr) got.push_back(s_rd_data);
    @(posedge clk);
    if (!r || f) begin
      q.delete();
      ov = 0;
    end else begin
      re = ram > 0 && (!ov || rr);
      if (ov && rr) void'(q.pop_front());
      if (wv && exp_wr) begin
        q.push_back(wd);
        sent.push_back(wd);
      end
      ov = re ? 1'b1 : (rr ? 1'b0 : ov);
    end
    #1;
  endtask
  task automatic cmp_stream(input string n);
    chk({n, "_len"}, 32'(got.size()), 32'(sent.size()));
    for (int i = 0; i < got.size() && i < sent.size(); i++) chk(n, got[i], sent[i]);
    got.delete();
    sent.delete();
  endtask
  initial begin
    logic [31:0] hold;
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    ov = 0;
    vecs[0] = '{0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0};
    vecs[1] = '{1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0};
    vecs[2] = '{1, 0, 1, 32'hA5A5_0001, 0, 1, 0, 0, 32'h0};
    vecs[3] = '{1, 0, 0, 32'h0, 0, 1, 0, 1, 32'h0};
    vecs[4] = '{1, 0, 0, 32'h0, 0, 1, 1, 1, 32'hA5A5_0001};
    vecs[5] = '{1, 0, 0, 32'h0, 1, 1, 1, 1, 32'hA5A5_0001};
    vecs[6] = '{1, 0, 0, 32'h0, 0, 1, 0, 0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      cyc(vecs[i].r, vecs[i].f, vecs[i].wv, vecs[i].wd, vecs[i].rr);
      chk($sformatf("vec%0d_wr_ready", i), 32'(s_wr_ready), 32'(vecs[i].ewr));
      chk($sformatf("vec%0d_rd_valid", i), 32'(s_rd_valid), 32'(vecs[i].erv));
      chk($sformatf("vec%0d_count", i), s_count, 32'(vecs[i].ecnt));
      if (vecs[i].erv) chk($sformatf("vec%0d_rd_data", i), s_rd_data, vecs[i].edata);
    end
    got.delete(); sent.delete();
    for (int i = 0; i <= 20; i++) cyc(1, 0, 1, 32'(i), 0);
    cyc(1, 0, 0, 0, 0);
    chk("fill_count", s_count, 32'd17);
    chk("fill_wr_ready", 32'(s_wr_ready), 32'd0);
    repeat (20) cyc(1, 0, 0, 0, 1);
    chk("fill_drain_len", 32'(got.size()), 32'd17);
    for (int i = 0; i < got.size(); i++) chk("fill_drain_data", got[i], 32'(i));
    got.delete(); sent.delete();
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 32'h100 + 32'(i), 0);
    cyc(1, 0, 0, 0, 0);
    hold = s_rd_data;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1, 32'h200 + 32'(k), 0);
      chk("stall_valid", 32'(s_rd_valid), 32'd1);
      chk("stall_data", s_rd_data, hold);
    end
    chk("stall_head", hold, 32'h100);
    repeat (12) cyc(1, 0, 0, 0, 1);
    cmp_stream("stall_order");
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 1, 32'd1000 + 32'(i), 1);
      if (i >= 2) chk("stream_count", s_count, 32'd2);
    end
    repeat (4) cyc(1, 0, 0, 0, 1);
    cmp_stream("stream_order");
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 32'd200 + 32'(i), 0);
    cyc(1, 0, 1, 32'd500, 1);
    chk("full_count", s_count, 32'd17);
    chk("full_pushpop_wr_ready", 32'(s_wr_ready), 32'd0);
    cyc(1, 0, 1, 32'd501, 0);
    chk("full_after_pop_wr_ready", 32'(s_wr_ready), 32'd1);
    repeat (20) cyc(1, 0, 0, 0, 1);
    chk("full_drain_len", 32'(got.size()), 32'd18);
    cmp_stream("full_order");
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 32'd300 + 32'(i), 0);
    cyc(1, 1, 1, 32'd777, 0);
    chk("flush_at_count", s_count, 32'd9);
    chk("flush_wr_ready", 32'(s_wr_ready), 32'd0);
    repeat (3) begin
      cyc(1, 0, 0, 0, 1);
      chk("flush_count", s_count, 32'd0);
      chk("flush_rd_valid", 32'(s_rd_valid), 32'd0);
    end
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 32'd400 + 32'(i), 0);
    cyc(0, 1, 1, 32'd888, 0);
    chk("rst_wr_ready", 32'(s_wr_ready), 32'd0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_count", s_count, 32'd0);
    chk("rst_rd_valid", 32'(s_rd_valid), 32'd0);
    chk("rst_release_wr_ready", 32'(s_wr_ready), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 500) % 3;
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 63) == 0,
          $urandom_range(0, 3) >= bias, $urandom, $urandom_range(0, 3) <= bias);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
